ram_dump_streamer: RTL and testbench

- Reader-side companion to the Hack computer's data RAM.
- When the computer raises `ended`, the block walks a configured RAM window and streams each word out over a valid/ready interface.
- It gives hardware access to final RAM state, which otherwise exists only as a file dump.
- It sits beside the computer, shares the RAM through a dedicated synchronous read port, and feeds a UART or host-capture sink.

---
 rtl/ram_dump_streamer_if.sv | 51 +++++
 rtl/ram_dump_streamer.sv | 164 ++++++++++++++++
 tb/tb_ram_dump_streamer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_streamer_if.sv
// rtl/ram_dump_streamer_if.sv - RAM read port and dump stream bundle for ram_dump_streamer
//
// Purpose: groups the synchronous RAM read port and the valid/ready word
// stream into one bundle.
//
// Signals:
//   ram_addr  [ADDR_WIDTH] streamer -> RAM    read address
//   ram_rd                 streamer -> RAM    read strobe; data one cycle later
//   ram_rdata [16]         RAM -> streamer    read data
//   out_valid              streamer -> sink   stream word valid
//   out_ready              sink -> streamer   sink accepts word
//   out_data  [16]         streamer -> sink   streamed RAM word
//   out_addr  [ADDR_WIDTH] streamer -> sink   RAM address of out_data
//   out_last               streamer -> sink   final word of the dump
//
// Modports: master = streamer side, slave = RAM/sink side.

interface ram_dump_streamer_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_rd;
  logic [15:0]           ram_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;

  modport master (
    output ram_addr,
    output ram_rd,
    input  ram_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_last
  );

  modport slave (
    input  ram_addr,
    input  ram_rd,
    output ram_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_last
  );
endinterface

// File: rtl/ram_dump_streamer.sv
// rtl/ram_dump_streamer.sv - streams a RAM window over valid/ready once the computer halts
//
// Purpose: when ended_i is seen high in IDLE, walks DUMP_LEN words starting
// at BASE_ADDR (wrapping modulo 2^ADDR_WIDTH). It does one synchronous RAM
// read per word and presents each word with its address on a valid/ready
// stream. After the last word it parks in DONE until reset.
//
// Ports:
//   clk_i    in   system clock, rising edge
//   reset_i  in   asynchronous active-low reset
//   ended_i  in   computer halt flag, level-sensed start trigger
//   busy_o   out  dump in progress
//   done_o   out  dump complete, sticky until reset
//   dump_if  master modport: RAM read port and output word stream

module ram_dump_streamer #(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned DUMP_LEN   = 32,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                ended_i,
  output logic                busy_o,
  output logic                done_o,
  ram_dump_streamer_if.master dump_if
);

  // One extra bit so a full 2^ADDR_WIDTH word dump can be counted.
  localparam int unsigned           CNT_W    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(DUMP_LEN - 1);
  localparam bit                    EMPTY    = (DUMP_LEN == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_VALID,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_rd_q, ram_rd_d;
  logic                  out_valid_q, out_valid_d;
  logic [15:0]           out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // All outputs are registered. The next-state logic sets each output for
  // the state being entered, so every output lines up with state_q.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_rd_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE: begin
        if (ended_i) begin
          if (EMPTY) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            ram_rd_d   = 1'b1;
            ram_addr_d = ptr_q;
            busy_d     = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      // The read issued in ISSUE returns during this cycle.
      S_WAIT: begin
        out_data_d  = dump_if.ram_rdata;
        out_addr_d  = ptr_q;
        out_last_d  = (cnt_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = S_VALID;
      end

      S_VALID: begin
        if (dump_if.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else begin
            // Natural wrap at the top of the address space.
            ptr_d      = ptr_q + ADDR_WIDTH'(1);
            cnt_d      = cnt_q + CNT_W'(1);
            ram_addr_d = ptr_q + ADDR_WIDTH'(1);
            ram_rd_d   = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end

      // Terminal until reset; ended_i is ignored.
      S_DONE: begin
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= BASE;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_rd_q    <= ram_rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dump_if.ram_addr  = ram_addr_q;
  assign dump_if.ram_rd    = ram_rd_q;
  assign dump_if.out_valid = out_valid_q;
  assign dump_if.out_data  = out_data_q;
  assign dump_if.out_addr  = out_addr_q;
  assign dump_if.out_last  = out_last_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;

endmodule

// File: tb/tb_ram_dump_streamer.sv
// tb/tb_ram_dump_streamer.sv - self-checking bench for ram_dump_streamer

module tb_ram_dump_streamer;

  localparam int N = 4;
  // Instance configs {inst3, inst2, inst1, inst0}
  localparam logic [3:0][31:0] BASES = {32'h100, 32'h0, 32'h7FFE, 32'h0};
  localparam logic [3:0][31:0] LENS  = {32'd8, 32'd0, 32'd4, 32'd3};

  logic clk;
  logic rst_n;
  logic [3:0] ended, man_ready, rnd_ready, ready;
  logic rand_mode;
  logic [3:0] rd, vld, olast, busy, done;
  logic [3:0][14:0] raddr, oaddr;
  logic [3:0][15:0] odata;
  logic [15:0] mem [32768];

  assign ready = rand_mode ? rnd_ready : man_ready;

  typedef struct {
    int          inst;
    logic [14:0] addr;
    logic [15:0] data;
    logic        last;
  } hs_t;

  typedef struct {
    logic        ended;
    logic        ready;
    logic        rd;
    logic        vld;
    logic        last;
    logic        busy;
    logic        done;
    logic [14:0] addr;
    logic [15:0] data;
  } row_t;

  hs_t hs[$];
  int rd_cnt [N];
  int vld_cnt [N];
  int busy_cnt [N];
  int proto_err;
  int n_cmp, n_fail;

  logic [3:0] pstall, prd, pl;
  logic [3:0][15:0] pd;
  logic [3:0][14:0] pa;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_dump_streamer_if #(.ADDR_WIDTH(15)) bus ();
    logic [15:0] rdata_l;

    ram_dump_streamer #(
      .BASE_ADDR (BASES[g]),
      .DUMP_LEN  (LENS[g]),
      .ADDR_WIDTH(15)
    ) u_dut (
      .clk_i  (clk),
      .reset_i(rst_n),
      .ended_i(ended[g]),
      .busy_o (busy[g]),
      .done_o (done[g]),
      .dump_if(bus)
    );

    always @(posedge clk) if (bus.ram_rd) rdata_l <= mem[bus.ram_addr];
    assign bus.ram_rdata = rdata_l;
    assign bus.out_ready = ready[g];
    assign rd[g]    = bus.ram_rd;
    assign raddr[g] = bus.ram_addr;
    assign vld[g]   = bus.out_valid;
    assign odata[g] = bus.out_data;
    assign oaddr[g] = bus.out_addr;
    assign olast[g] = bus.out_last;
  end

  initial begin
    rnd_ready = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = 4'($urandom);
    end
  end

  // Monitor: handshake log, read/valid/busy counts, protocol watch.
  initial begin
    hs_t r;
    proto_err = 0;
    pstall = '0;
    prd = '0;
    pl = '0;
    pd = '0;
    pa = '0;
    for (int i = 0; i < N; i++) begin
      rd_cnt[i] = 0;
      vld_cnt[i] = 0;
      busy_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst_n !== 1'b1) begin
          pstall[i] = 1'b0;
          prd[i] = 1'b0;
        end else begin
          if (rd[i]) rd_cnt[i]++;
          if (vld[i]) vld_cnt[i]++;
          if (busy[i]) busy_cnt[i]++;
          if (rd[i] && (prd[i] || vld[i])) proto_err++;
          if (pstall[i] && (!vld[i] || odata[i] !== pd[i] || oaddr[i] !== pa[i] || olast[i] !== pl[i]))
            proto_err++;
          if (vld[i] && ready[i]) begin
            r.inst = i;
            r.addr = oaddr[i];
            r.data = odata[i];
            r.last = olast[i];
            hs.push_back(r);
          end
          pstall[i] = vld[i] & ~ready[i];
          pd[i] = odata[i];
          pa[i] = oaddr[i];
          pl[i] = olast[i];
          prd[i] = rd[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int count_hs(input int i, input int s);
    int c = 0;
    for (int j = s; j < hs.size(); j++) if (hs[j].inst == i) c++;
    return c;
  endfunction

  // Reference model: word k of a dump is RAM[(base + k) mod 2^15], last on k == len-1.
  task automatic check_dump(input int i, input int s, input string nm);
    int k = 0;
    int base = int'(BASES[i]);
    int len = int'(LENS[i]);
    int a;
    logic [31:0] exp_v, act_v;
    for (int j = s; j < hs.size(); j++) begin
      if (hs[j].inst == i) begin
        if (k < len) begin
          a = (base + k) % 32768;
          exp_v = {(k == len - 1), 15'(a), mem[a]};
          act_v = {hs[j].last, hs[j].addr, hs[j].data};
          chk($sformatf("%s_word%0d", nm, k), 64'(act_v), 64'(exp_v));
        end
        k++;
      end
    end
    chk($sformatf("%s_count", nm), 64'(k), 64'(len));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ended = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_ended(input int i);
    ended[i] = 1'b1;
    @(posedge clk);
    #1;
    ended[i] = 1'b0;
  endtask

  task automatic wait_vld(input int i, input int budget, input string nm);
    for (int n = 0; n < budget && !vld[i]; n++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_valid_seen", nm), 64'(vld[i]), 64'd1);
  endtask

  task automatic wait_done(input int i, input int budget, input string nm);
    for (int n = 0; n < budget && !done[i]; n++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_done", nm), 64'(done[i]), 64'd1);
  endtask

  initial begin
    row_t tbl [12];
    int s, r0, a;
    logic [14:0] a0;
    logic [15:0] d0;

    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    ended = '0;
    man_ready = 4'hF;
    rand_mode = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;

    //            ended ready rd vld last busy done addr data
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0, 16'd13};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0, 16'd13};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 16'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 15'd1, 16'd8};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 16'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0, 16'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'd2, 16'd104};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0, 16'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0, 16'd0};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("reset_state%0d", i),
          64'({vld[i], rd[i], olast[i], busy[i], done[i], odata[i], oaddr[i], raddr[i]}), 64'd0);
    rst_n = 1'b1;

    // Idle: no reads without ended
    r0 = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
    repeat (20) @(posedge clk);
    #1;
    chk("idle_reads", 64'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - r0), 64'd0);
    chk("idle_busy_done", 64'({busy, done}), 64'd0);

    // Mult result dump, cycle by cycle
    mem[0] = 16'd13;
    mem[1] = 16'd8;
    mem[2] = 16'd104;
    s = hs.size();
    r0 = rd_cnt[0];
    for (int k = 0; k < 12; k++) begin
      ended[0] = tbl[k].ended;
      man_ready[0] = tbl[k].ready;
      @(posedge clk);
      #1;
      chk($sformatf("mult_step%0d_ctl", k), 64'({rd[0], vld[0], olast[0], busy[0], done[0]}),
          64'({tbl[k].rd, tbl[k].vld, tbl[k].last, tbl[k].busy, tbl[k].done}));
      if (tbl[k].vld)
        chk($sformatf("mult_step%0d_word", k), 64'({oaddr[0], odata[0]}), 64'({tbl[k].addr, tbl[k].data}));
    end
    ended[0] = 1'b0;
    man_ready[0] = 1'b1;
    check_dump(0, s, "mult");
    chk("mult_reads", 64'(rd_cnt[0] - r0), 64'd3);

    // Sticky done: toggling ended does nothing
    r0 = rd_cnt[0];
    for (int k = 0; k < 10; k++) begin
      ended[0] = ~ended[0];
      @(posedge clk);
      #1;
    end
    ended[0] = 1'b0;
    chk("sticky_state", 64'({done[0], vld[0], busy[0]}), 64'b100);
    chk("sticky_reads", 64'(rd_cnt[0] - r0), 64'd0);

    // Zero-length dump
    r0 = rd_cnt[2] + vld_cnt[2] + busy_cnt[2];
    pulse_ended(2);
    chk("zero_done_next_cycle", 64'(done[2]), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("zero_no_activity", 64'(rd_cnt[2] + vld_cnt[2] + busy_cnt[2] - r0), 64'd0);

    // Address wrap-around
    mem[15'h7FFE] = 16'hAAAA;
    mem[15'h7FFF] = 16'h5555;
    mem[0] = 16'd1;
    mem[1] = 16'd2;
    s = hs.size();
    pulse_ended(1);
    wait_done(1, 100, "wrap");
    check_dump(1, s, "wrap");

    // Backpressure on first word
    do_reset();
    s = hs.size();
    man_ready[0] = 1'b0;
    pulse_ended(0);
    wait_vld(0, 20, "bp");
    a0 = oaddr[0];
    d0 = odata[0];
    r0 = rd_cnt[0];
    chk("bp_first_word", 64'({a0, d0}), 64'({15'd0, mem[0]}));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", k), 64'({vld[0], oaddr[0], odata[0]}), 64'({1'b1, a0, d0}));
    end
    chk("bp_no_reads", 64'(rd_cnt[0] - r0), 64'd0);
    man_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_read_after_hs", 64'({rd[0], vld[0]}), 64'b10);
    wait_done(0, 100, "bp");
    check_dump(0, s, "bp");

    // Reset mid-dump while word 3 is valid
    do_reset();
    for (int k = 0; k < 8; k++) mem[32'h100 + k] = 16'($urandom);
    s = hs.size();
    man_ready[3] = 1'b0;
    pulse_ended(3);
    for (int k = 0; k < 2; k++) begin
      wait_vld(3, 20, "rm");
      man_ready[3] = 1'b1;
      @(posedge clk);
      #1;
      man_ready[3] = 1'b0;
    end
    wait_vld(3, 20, "rm3");
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_outputs_zero",
        64'({vld[3], rd[3], olast[3], busy[3], done[3], odata[3], oaddr[3], raddr[3]}), 64'd0);
    chk("rm_hs_count", 64'(count_hs(3, s)), 64'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = rd_cnt[3];
    repeat (5) @(posedge clk);
    #1;
    chk("rm_idle_after", 64'({rd_cnt[3] - r0, busy[3], vld[3]}), 64'd0);
    s = hs.size();
    man_ready[3] = 1'b1;
    pulse_ended(3);
    wait_done(3, 100, "restart");
    check_dump(3, s, "restart");

    // Randomized data and backpressure on all instances
    rand_mode = 1'b1;
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      for (int i = 0; i < N; i++)
        for (int k = 0; k < int'(LENS[i]); k++) begin
          a = (int'(BASES[i]) + k) % 32768;
          mem[a] = 16'($urandom);
        end
      s = hs.size();
      ended = 4'hF;
      @(posedge clk);
      #1;
      ended = 4'h0;
      for (int i = 0; i < N; i++) wait_done(i, 300, $sformatf("rnd%0d_inst%0d", rnd, i));
      check_dump(0, s, $sformatf("rnd%0d_i0", rnd));
      check_dump(1, s, $sformatf("rnd%0d_i1", rnd));
      check_dump(2, s, $sformatf("rnd%0d_i2", rnd));
      check_dump(3, s, $sformatf("rnd%0d_i3", rnd));
    end
    rand_mode = 1'b0;

    chk("protocol_errors", 64'(proto_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
